// File: rtl/control_m.sv
// Opcode type shared with the datapath, plus the 8-phase instruction sequencer
// for the accumulator CPU.
package ex_type_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;
endpackage

module control_m
    import ex_type_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  opcode_e     opcode,
    input  logic        zero,
    output logic [2:0]  phase,
    output logic        sel,
    output logic        rd,
    output logic        ld_ir,
    output logic        halt,
    output logic        inc_pc,
    output logic        ld_ac,
    output logic        ld_pc,
    output logic        wr,
    output logic        data_e
);

    localparam logic [2:0] PhInstAddr  = 3'd0;
    localparam logic [2:0] PhInstFetch = 3'd1;
    localparam logic [2:0] PhInstLoad  = 3'd2;
    localparam logic [2:0] PhIdle      = 3'd3;
    localparam logic [2:0] PhOpAddr    = 3'd4;
    localparam logic [2:0] PhOpFetch   = 3'd5;
    localparam logic [2:0] PhAluOp     = 3'd6;
    localparam logic [2:0] PhStore     = 3'd7;

    logic [2:0] phase_q, phase_d;
    logic       halted_q, halted_d;
    logic       is_hlt, is_skz, is_sto, is_jmp, aluop;

    // Decoded with a case so an unknown opcode falls to the inactive default.
    always_comb begin
        is_hlt = 1'b0;
        is_skz = 1'b0;
        is_sto = 1'b0;
        is_jmp = 1'b0;
        aluop  = 1'b0;
        case (opcode)
            HLT:               is_hlt = 1'b1;
            SKZ:               is_skz = 1'b1;
            STO:               is_sto = 1'b1;
            JMP:               is_jmp = 1'b1;
            ADD, AND, XOR, LDA: aluop = 1'b1;
            default:           ;
        endcase
    end

    always_comb begin
        halted_d = halted_q | ((phase_q == PhOpAddr) & is_hlt);
        phase_d  = halted_d ? PhOpAddr : phase_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= PhInstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase  = phase_q;
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PhInstAddr: sel = 1'b1;
                PhInstFetch: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PhInstLoad, PhIdle: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PhOpAddr: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PhOpFetch: rd = aluop;
                PhAluOp: begin
                    rd     = aluop;
                    inc_pc = is_skz & zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PhStore: begin
                    rd     = aluop;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    ld_ac  = aluop;
                    data_e = is_sto;
                    wr     = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_m.sv
// Directed bench for control_m: expected output vectors are pushed to a queue as
// stimulus is applied and popped against the DUT between clock edges.
module tb_control_m;
    import ex_type_pkg::*;

    typedef struct packed {
        logic [2:0] phase;
        logic       sel;
        logic       rd;
        logic       ld_ir;
        logic       halt;
        logic       inc_pc;
        logic       ld_ac;
        logic       ld_pc;
        logic       wr;
        logic       data_e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_;
    opcode_e    opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];

    logic [2:0] m_phase;
    logic       m_halted;

    always #5 clk = ~clk;

    control_m dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e)
    );

    function automatic vec_t model(input logic [2:0] ph, input logic hd, input opcode_e op,
                                   input logic z);
        vec_t e;
        logic alu;
        alu = (op === ADD) || (op === AND) || (op === XOR) || (op === LDA);
        e = '0;
        if (hd) begin
            e.phase = 3'd4;
            e.halt  = 1'b1;
        end else begin
            e.phase  = ph;
            e.sel    = (ph <= 3'd3);
            e.rd     = ((ph >= 3'd1) && (ph <= 3'd3)) || ((ph >= 3'd5) && alu);
            e.ld_ir  = (ph == 3'd2) || (ph == 3'd3);
            e.inc_pc = (ph == 3'd4) || ((ph == 3'd6) && (op === SKZ) && z)
                       || ((ph == 3'd7) && (op === JMP));
            e.ld_pc  = (ph >= 3'd6) && (op === JMP);
            e.ld_ac  = (ph == 3'd7) && alu;
            e.data_e = (ph >= 3'd6) && (op === STO);
            e.wr     = (ph == 3'd7) && (op === STO);
            e.halt   = (ph == 3'd4) && (op === HLT);
        end
        return e;
    endfunction

    task automatic advance_model();
        if (!m_halted) begin
            if ((m_phase == 3'd4) && (opcode === HLT)) m_halted = 1'b1;
            else m_phase = m_phase + 3'd1;
        end
    endtask

    task automatic check(input string tag);
        vec_t act, e;
        sb.push_back(model(m_phase, m_halted, opcode, zero));
        act = {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
        e = sb.pop_front();
        total++;
        assert (act === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (ph,sel,rd,ldir,hlt,inc,ldac,ldpc,wr,de)",
                   tag, act, e);
        end
    endtask

    // Entered just after a negedge; leaves just after the following negedge.
    task automatic cyc(input opcode_e op, input logic z, input string tag);
        opcode = op;
        zero   = z;
        #1;
        check($sformatf("%s_ph%0d", tag, m_phase));
        @(posedge clk);
        advance_model();
        @(negedge clk);
    endtask

    task automatic run_inst(input opcode_e op, input logic z, input string tag);
        for (int i = 0; i < 8; i++) cyc(op, z, tag);
    endtask

    // Pulse reset between clock edges and check outputs respond without an edge.
    task automatic async_reset(input string tag);
        #1;
        rst_ = 1'b0;
        #1;
        m_phase  = 3'd0;
        m_halted = 1'b0;
        check({tag, "_low"});
        #1;
        rst_ = 1'b1;
        #1;
        check({tag, "_rel"});
        @(posedge clk);
        advance_model();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_     = 1'b0;
        opcode   = ADD;
        zero     = 1'b0;
        m_phase  = 3'd0;
        m_halted = 1'b0;
        #2;
        check("reset_hold");
        @(negedge clk);
        // Flip the inputs during reset: outputs must not care.
        opcode = JMP;
        zero   = 1'b1;
        #1;
        check("reset_inputs");
        rst_ = 1'b1;
        #1;

        run_inst(ADD, 1'b0, "add");
        cyc(ADD, 1'b0, "add_wrap");
        for (int i = 0; i < 7; i++) cyc(ADD, 1'b0, "add2");
        run_inst(STO, 1'b0, "sto");
        run_inst(SKZ, 1'b1, "skz_z1");
        run_inst(SKZ, 1'b0, "skz_z0");
        run_inst(JMP, 1'b1, "jmp");
        run_inst(XOR, 1'b1, "xor_z1");
        run_inst(LDA, 1'b0, "lda");
        run_inst(AND, 1'b1, "and");

        for (int i = 0; i < 5; i++) cyc(ADD, 1'b1, "pre_rst");
        async_reset("rst_ph5");
        for (int i = 0; i < 7; i++) cyc(ADD, 1'b0, "post_rst");

        for (int i = 0; i < 5; i++) cyc(HLT, 1'b0, "hlt");
        for (int i = 0; i < 12; i++) cyc(((i % 2) == 0) ? ADD : STO, i[0], "halted");
        async_reset("rst_halted");
        for (int i = 0; i < 7; i++) cyc(JMP, 1'b0, "after_halt");
        run_inst(SKZ, 1'b1, "final_skz");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_m.md
CONTROL_M -- requirements
Module: control_m

Interface
REQ-001 Parameters: none; opcode type SHALL be opcode_e imported from ex_type_pkg (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  opcode_e (3)  current instruction opcode from instruction register.
REQ-005 zero  input  1  ALU accumulator-is-zero flag.
REQ-006 phase  output  3  current phase, 0..7.
REQ-007 sel  output  1  address mux select: 1 = program counter, 0 = instruction operand.
REQ-008 rd  output  1  memory read enable.
REQ-009 ld_ir  output  1  instruction register load.
REQ-010 halt  output  1  processor halted.
REQ-011 inc_pc  output  1  program counter increment.
REQ-012 ld_ac  output  1  accumulator load from ALU output.
REQ-013 ld_pc  output  1  program counter load from operand.
REQ-014 wr  output  1  memory write strobe.
REQ-015 data_e  output  1  accumulator drives data bus.

Function
REQ-016 Phase counter SHALL advance by 1 every posedge clk, wrapping 7 -> 0; one instruction every 8 cycles.
REQ-017 Phase names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-018 ALUOP SHALL be 1 when opcode is ADD, AND, XOR or LDA; else 0.
REQ-019 Outputs SHALL be combinational decodes of (phase, opcode, zero, halted state); no extra latency.
REQ-020 sel = 1 in phases 0-3, else 0.
REQ-021 rd = 1 in phases 1-3; = ALUOP in phases 5-7; else 0.
REQ-022 ld_ir = 1 in phases 2-3; else 0.
REQ-023 inc_pc = 1 in phase 4; = (opcode==SKZ && zero) in phase 6; = (opcode==JMP) in phase 7; else 0.
REQ-024 ld_pc = (opcode==JMP) in phases 6-7; else 0.
REQ-025 ld_ac = ALUOP in phase 7; else 0.
REQ-026 data_e = (opcode==STO) in phases 6-7; wr = (opcode==STO) in phase 7 only; else 0.
REQ-027 Halt: at posedge clk leaving phase 4 with opcode==HLT, a sticky halted flag SHALL set and phase SHALL freeze at 4.
REQ-028 While halted: halt = 1, phase = 4, inc_pc/ld_pc/ld_ac/wr/data_e/rd/ld_ir = 0, sel = 0; opcode and zero changes ignored.
REQ-029 halt SHALL also be 1 combinationally in phase 4 when opcode==HLT, before the flag sets.
REQ-030 Halted state SHALL be exited only by reset.
REQ-031 zero SHALL affect outputs only in phase 6 for SKZ; zero ignored for every other opcode and phase.
REQ-032 Unknown/X opcode SHALL not change phase sequencing.

Reset
REQ-033 rst_ low SHALL immediately (asynchronously) force phase = 0 and clear halted flag, regardless of clock.
REQ-034 During reset outputs SHALL read sel=1, all other outputs 0.
REQ-035 Reset asserted mid-instruction (any phase, including halted) SHALL abandon the instruction; first posedge after rst_ rises SHALL move phase 0 -> 1.

Verification
REQ-036 Reset release, opcode=ADD, zero=0, 8 clocks -> phase 0..7 then 0; rd=1 phases 1-3 and 5-7; ld_ir=1 phases 2-3; inc_pc=1 phase 4 only; ld_ac=1 phase 7 only.
REQ-037 opcode=STO, 8 clocks -> rd=0 phases 5-7; data_e=1 phases 6-7; wr=1 phase 7 only; ld_ac=0 throughout.
REQ-038 opcode=SKZ: zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only; ld_pc=0 throughout.
REQ-039 opcode=JMP -> ld_pc=1 in phases 6-7; inc_pc=1 in phases 4 and 7; wr=0.
REQ-040 opcode=HLT at phase 4 -> halt=1 in phase 4; after next posedge phase stays 4, halt=1 for 10+ clocks with opcode changed to ADD; all strobes 0.
REQ-041 rst_ pulsed low mid-clock in phase 5, and again while halted -> phase=0, halt=0 immediately without a clock edge; normal sequencing resumes.
